rgb2hsv_pipe: RTL and testbench
===============================

Name: rgb2hsv_pipe

Overview:
Fully pipelined RGB-to-HSV converter for the vision datapath. It accepts one pixel per clock and produces hue, saturation and value for each pixel. Hue is fixed-point; saturation and value are channel-width integers. Input and output use a valid/ready stream handshake with full backpressure, and a user sideband (e.g. SOF/EOL) travels aligned with each pixel.

Parameters:
CW, 8, width of each R/G/B channel and of the S and V outputs
FRAC, 4, fractional bits of hue (1 LSB = 2^-FRAC degree)
USERW, 2, sideband width carried alongside each pixel

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input pixel valid
in_ready  out  1  converter can accept a pixel this cycle
in_r  in  CW  red channel
in_g  in  CW  green channel
in_b  in  CW  blue channel
in_user  in  USERW  sideband, passed through unchanged
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts this cycle
out_h  out  9+FRAC  hue, range [0, 360<<FRAC)
out_s  out  CW  saturation
out_v  out  CW  value
out_user  out  USERW  sideband aligned with out_h/s/v

Behaviour:
- Reset and clock: rst is asynchronous and active-high; clk is the clock. All valid bits, out_h, out_s, out_v and out_user reset to 0. Internal data registers need no reset.
- Transfers: an input transfer occurs when in_valid and in_ready are both high. An output transfer occurs when out_valid and out_ready are both high.
- Pipeline enable: en = !(out_valid && !out_ready). in_ready = en. All stages advance together when en=1 and hold when en=0. Bubbles are not squeezed out.
- Latency: QW = max(6+FRAC, CW). LAT = QW+2 cycles from input transfer to out_valid, when there are no stalls. Defaults give LAT = 12. Throughput is 1 pixel per clock.
- Stage 0 computes:
  - cmax, cmin, diff = cmax-cmin.
  - Sector, with tie priority R, then G, then B: R if r>=g and r>=b; else G if g>=b; else B.
  - Numerator n and sign:
    - Sector R: n=g-b, positive if g>=b, else n=b-g, negative.
    - Sector G: n=b-r, positive if b>=r, else n=r-b, negative.
    - Sector B: n=r-g, positive if r>=g, else n=g-r, negative.
- Stages 1..QW: two lockstep restoring dividers, one quotient bit per stage, MSB first.
  - qh = floor(n*60*2^FRAC / diff), width 6+FRAC. Note n<=diff, so qh<=60<<FRAC.
  - qs = floor(diff*(2^CW-1) / cmax), width CW.
  - A divider narrower than QW pads with leading zero stages.
- Final stage computes hue:
  - Sector R: h = qh if positive, else (360<<FRAC)-qh.
  - Sector G: h = (120<<FRAC) ± qh.
  - Sector B: h = (240<<FRAC) ± qh.
  - The result is always < 360<<FRAC; no wrap occurs.
- Final outputs: out_v = cmax. out_s = qs.
- Boundary conditions:
  - diff==0 (grey): h=0 and s=0. Division is bypassed and the divide-by-zero result is ignored.
  - cmax==0 (black): s=0 and v=0.
- Stalls: out_* hold stable while out_valid && !out_ready. in_ready is low in the same cycle, and no input is lost or duplicated.
- Reset mid-stream: all in-flight pixels are discarded. out_valid is 0 on the first cycle after reset deasserts, and in_ready is 1.

Decomposition:
- Package rgb2hsv_pkg:
  - sector_t enum {SEC_R, SEC_G, SEC_B}.
  - Hue constant functions deg(x) = x<<FRAC for 120, 240 and 360.
  - QW/LAT computation functions.
  - Struct type for the per-stage payload (sector, sign, cmax, user).
- Sub-module pipe_div: parametrised NUMW/DENW/QW restoring divider with en and a valid chain. It is instantiated twice, for hue and for saturation.

Test Plan (defaults, out_ready=1 unless stated):
- (255,0,0) -> H=0, S=255, V=255. (0,255,0) -> H=1920. (0,0,255) -> H=3840. Each arrives exactly 12 cycles after acceptance.
- (200,100,50) -> H=320, S=191, V=200. (255,128,0) -> H=481, S=255, V=255.
- Ties and wrap: (255,0,255) -> sector R negative, H=4800. (128,128,128) -> H=0, S=0, V=128. (0,0,0) -> all zero.
- Backpressure: stream 30 random pixels with in_user incrementing, and hold out_ready low for cycles 15-19.
  - Required: in_ready is low in exactly those cycles and outputs are stable.
  - Required: all 30 results match the golden model in order, with matching user values.
- Gapped input: in_valid toggles randomly -> output count equals input count, order preserved, no spurious out_valid.
- Assert rst for 1 cycle while 8 pixels are in flight -> out_valid=0 and outputs zero the next cycle, and none of the 8 pixels appears afterwards.

Source files
------------

// File: rtl/rgb2hsv_pkg.sv
// Shared types and constants for the pipelined RGB-to-HSV converter.
package rgb2hsv_pkg;

   localparam int PIX_CW   = 8;
   localparam int HUE_FRAC = 4;
   localparam int USER_W   = 2;

   typedef enum logic [1:0] {
      SEC_R = 2'd0,
      SEC_G = 2'd1,
      SEC_B = 2'd2
   } sector_t;

   // Side payload that rides alongside the two dividers.
   typedef struct packed {
      sector_t             sector;
      logic                neg;
      logic                grey;
      logic [PIX_CW-1:0]   cmax;
      logic [USER_W-1:0]   user;
   } stage_pay_t;

   function automatic int calc_qw(input int cw, input int frac);
      return (6 + frac > cw) ? 6 + frac : cw;
   endfunction

   function automatic int calc_lat(input int cw, input int frac);
      return calc_qw(cw, frac) + 2;
   endfunction

   function automatic logic [31:0] deg(input int x, input int frac);
      return 32'(x) << frac;
   endfunction

endpackage

// File: rtl/pipe_div.sv
// Restoring divider, one quotient bit per stage MSB first; stages above the
// quotient width are pass-through so several dividers can share one depth.
module pipe_div #(
   parameter int NUMW = 18,
   parameter int DENW = 8,
   parameter int QBW  = 10,
   parameter int QW   = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            in_valid,
   input  logic [NUMW-1:0] in_num,
   input  logic [DENW-1:0] in_den,
   output logic            out_valid,
   output logic [QBW-1:0]  out_q
);

   localparam int XW = NUMW + DENW + QW;

   for (genvar s = 0; s < QW; s++) begin : g_stg
      localparam int B = QW - 1 - s;
      logic [NUMW-1:0] rem_in;
      logic [DENW-1:0] den_in;
      logic [QBW-1:0]  q_in, q_d, q_q;
      logic            vld_in, vld_q, ge;

      if (s == 0) begin : g_head
         assign rem_in = in_num;
         assign den_in = in_den;
         assign q_in   = '0;
         assign vld_in = in_valid;
      end else begin : g_link
         assign rem_in = g_stg[s-1].g_carry.rem_q;
         assign den_in = g_stg[s-1].g_carry.den_q;
         assign q_in   = g_stg[s-1].q_q;
         assign vld_in = g_stg[s-1].vld_q;
      end

      if (B >= QBW) begin : g_pad
         assign ge = 1'b0;
      end else begin : g_cmp
         assign ge = XW'(rem_in) >= (XW'(den_in) << B);
      end

      always_comb begin
         q_d = q_in;
         if (ge) q_d = q_in | (QBW'(1) << B);
      end

      // The last stage only needs its quotient; the remainder dies here.
      if (s < QW - 1) begin : g_carry
         logic [NUMW-1:0] rem_d, rem_q;
         logic [DENW-1:0] den_q;
         always_comb begin
            rem_d = rem_in;
            if (ge) rem_d = NUMW'(XW'(rem_in) - (XW'(den_in) << B));
         end
         always_ff @(posedge clk) begin
            if (en) begin
               rem_q <= rem_d;
               den_q <= den_in;
            end
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst)     vld_q <= 1'b0;
         else if (en) vld_q <= vld_in;
      end

      always_ff @(posedge clk) begin
         if (en) q_q <= q_d;
      end
   end

   assign out_valid = g_stg[QW-1].vld_q;
   assign out_q     = g_stg[QW-1].q_q;

endmodule

// File: rtl/rgb2hsv_pipe.sv
// Fully pipelined RGB-to-HSV converter with a global stall enable; one pixel
// per clock, fixed-point hue, integer saturation/value, aligned user sideband.
module rgb2hsv_pipe
   import rgb2hsv_pkg::*;
#(
   parameter int CW    = PIX_CW,
   parameter int FRAC  = HUE_FRAC,
   parameter int USERW = USER_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW-1:0]    in_r,
   input  logic [CW-1:0]    in_g,
   input  logic [CW-1:0]    in_b,
   input  logic [USERW-1:0] in_user,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [8+FRAC:0]  out_h,
   output logic [CW-1:0]    out_s,
   output logic [CW-1:0]    out_v,
   output logic [USERW-1:0] out_user
);

   localparam int QW  = calc_qw(CW, FRAC);
   localparam int HQW = 6 + FRAC;
   localparam int HNW = CW + HQW;
   localparam int SNW = 2 * CW;
   localparam int HW  = 9 + FRAC;
   localparam logic [HW-1:0] DEG120 = HW'(deg(120, FRAC));
   localparam logic [HW-1:0] DEG240 = HW'(deg(240, FRAC));
   localparam logic [HW-1:0] DEG360 = HW'(deg(360, FRAC));

   logic en;
   logic [CW-1:0] cmax_c, cmin_c, diff_c, n_c;
   sector_t sec_c;
   logic neg_c;

   stage_pay_t s0_pay_d, s0_pay_q;
   logic [HNW-1:0] s0_hnum_d, s0_hnum_q;
   logic [SNW-1:0] s0_snum_d, s0_snum_q;
   logic [CW-1:0]  s0_diff_q;
   logic           s0_vld_q;

   stage_pay_t pay_d [QW];
   stage_pay_t pay_q [QW];
   stage_pay_t fin_pay;

   logic hdiv_vld, sdiv_vld;
   logic [HQW-1:0] qh;
   logic [CW-1:0]  qs;
   logic [HW-1:0]  h_c;

   logic             out_valid_d, out_valid_q;
   logic [HW-1:0]    out_h_d, out_h_q;
   logic [CW-1:0]    out_s_d, out_s_q, out_v_d, out_v_q;
   logic [USERW-1:0] out_user_d, out_user_q;

   assign en       = !(out_valid_q && !out_ready);
   assign in_ready = en;

   // Sector ties resolve R, then G, then B.
   always_comb begin
      cmax_c = in_r;
      cmin_c = in_r;
      if (in_g > cmax_c) cmax_c = in_g;
      if (in_b > cmax_c) cmax_c = in_b;
      if (in_g < cmin_c) cmin_c = in_g;
      if (in_b < cmin_c) cmin_c = in_b;
      diff_c = cmax_c - cmin_c;
      if (in_r >= in_g && in_r >= in_b) begin
         sec_c = SEC_R;
         neg_c = in_g < in_b;
         n_c   = neg_c ? in_b - in_g : in_g - in_b;
      end else if (in_g >= in_b) begin
         sec_c = SEC_G;
         neg_c = in_b < in_r;
         n_c   = neg_c ? in_r - in_b : in_b - in_r;
      end else begin
         sec_c = SEC_B;
         neg_c = in_r < in_g;
         n_c   = neg_c ? in_g - in_r : in_r - in_g;
      end
      s0_pay_d  = '{sector: sec_c, neg: neg_c, grey: (diff_c == '0),
                    cmax: cmax_c, user: in_user};
      s0_hnum_d = HNW'(n_c) * HNW'(60 << FRAC);
      s0_snum_d = (SNW'(diff_c) << CW) - SNW'(diff_c);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)     s0_vld_q <= 1'b0;
      else if (en) s0_vld_q <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (en) begin
         s0_pay_q  <= s0_pay_d;
         s0_hnum_q <= s0_hnum_d;
         s0_snum_q <= s0_snum_d;
         s0_diff_q <= diff_c;
      end
   end

   always_comb begin
      pay_d[0] = s0_pay_q;
      for (int i = 1; i < QW; i++) pay_d[i] = pay_q[i-1];
   end

   always_ff @(posedge clk) begin
      if (en) pay_q <= pay_d;
   end

   pipe_div #(.NUMW(HNW), .DENW(CW), .QBW(HQW), .QW(QW)) u_hue_div (
      .clk(clk), .rst(rst), .en(en), .in_valid(s0_vld_q),
      .in_num(s0_hnum_q), .in_den(s0_diff_q),
      .out_valid(hdiv_vld), .out_q(qh)
   );

   pipe_div #(.NUMW(SNW), .DENW(CW), .QBW(CW), .QW(QW)) u_sat_div (
      .clk(clk), .rst(rst), .en(en), .in_valid(s0_vld_q),
      .in_num(s0_snum_q), .in_den(s0_pay_q.cmax),
      .out_valid(sdiv_vld), .out_q(qs)
   );

   assign fin_pay = pay_q[QW-1];

   // Grey pixels divided by zero; their quotients are discarded here.
   always_comb begin
      case (fin_pay.sector)
         SEC_G:   h_c = fin_pay.neg ? DEG120 - HW'(qh) : DEG120 + HW'(qh);
         SEC_B:   h_c = fin_pay.neg ? DEG240 - HW'(qh) : DEG240 + HW'(qh);
         default: h_c = fin_pay.neg ? DEG360 - HW'(qh) : HW'(qh);
      endcase
      out_valid_d = hdiv_vld & sdiv_vld;
      out_h_d     = fin_pay.grey ? '0 : h_c;
      out_s_d     = fin_pay.grey ? '0 : qs;
      out_v_d     = fin_pay.cmax;
      out_user_d  = fin_pay.user;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_h_q     <= '0;
         out_s_q     <= '0;
         out_v_q     <= '0;
         out_user_q  <= '0;
      end else if (en) begin
         out_valid_q <= out_valid_d;
         out_h_q     <= out_h_d;
         out_s_q     <= out_s_d;
         out_v_q     <= out_v_d;
         out_user_q  <= out_user_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_h     = out_h_q;
   assign out_s     = out_s_q;
   assign out_v     = out_v_q;
   assign out_user  = out_user_q;

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Scoreboard bench for rgb2hsv_pipe: directed vectors with hand-computed HSV,
// backpressure, gapped input and a mid-stream reset.
module tb_rgb2hsv_pipe;

   localparam int CW    = 8;
   localparam int FRAC  = 4;
   localparam int USERW = 2;
   localparam int HW    = 9 + FRAC;
   localparam int EW    = HW + 2 * CW + USERW;
   localparam int LAT   = 12;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [CW-1:0]    in_r = '0, in_g = '0, in_b = '0;
   logic [USERW-1:0] in_user = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [HW-1:0]    out_h;
   logic [CW-1:0]    out_s, out_v;
   logic [USERW-1:0] out_user;

   rgb2hsv_pipe dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_user(in_user),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_h(out_h), .out_s(out_s), .out_v(out_v), .out_user(out_user)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   logic [EW-1:0] exp_q[$];
   int            lat_q[$];
   int            errors = 0;
   int            checks = 0;
   int            n_out  = 0;

   function automatic logic [EW-1:0] pk(input int h, input int s, input int v, input int u);
      return {HW'(h), CW'(s), CW'(v), USERW'(u)};
   endfunction

   // Golden model: signed hue offset inside the winning sector, wrapped into [0,360).
   function automatic logic [EW-1:0] model(input int r, input int g, input int b, input int u);
      int mx, mn, d, num, base, mag, h, s;
      mx = (r > g) ? r : g;  mx = (b > mx) ? b : mx;
      mn = (r < g) ? r : g;  mn = (b < mn) ? b : mn;
      d  = mx - mn;
      h = 0; s = 0;
      if (d != 0) begin
         s = d * 255 / mx;
         if (r >= g && r >= b) begin num = g - b; base = 0;    end
         else if (g >= b)      begin num = b - r; base = 1920; end
         else                  begin num = r - g; base = 3840; end
         mag = ((num < 0) ? -num : num) * 960 / d;
         h = base + ((num < 0) ? -mag : mag);
         if (h < 0) h = h + 5760;
      end
      return pk(h, s, mx, u);
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // Monitor: pops on every output transfer and checks stall stability.
   logic          prev_stall = 1'b0;
   logic          prev_vld = 1'b0;
   logic [EW-1:0] prev_pix = '0;
   always begin
      logic [EW-1:0] got, exp;
      int            acc;
      @(negedge clk);
      #2;
      got = {out_h, out_s, out_v, out_user};
      if (prev_stall) begin
         checks++;
         if ({out_valid, got} !== {prev_vld, prev_pix}) begin
            errors++;
            $display("FAIL stall_hold got=%h exp=%h", {out_valid, got}, {prev_vld, prev_pix});
         end
      end
      if (!rst && out_valid && out_ready) begin
         n_out++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_out got h=%0d s=%0d v=%0d u=%0d exp none",
                     out_h, out_s, out_v, out_user);
         end else begin
            exp = exp_q.pop_front();
            acc = lat_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL out_pix got h=%0d s=%0d v=%0d u=%0d exp h=%0d s=%0d v=%0d u=%0d",
                        out_h, out_s, out_v, out_user,
                        exp[EW-1 -: HW], exp[2*CW+USERW-1 -: CW], exp[CW+USERW-1 -: CW],
                        exp[USERW-1:0]);
            end
            if (acc >= 0) chk("latency", cyc_cnt - acc, LAT);
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_vld   = out_valid;
      prev_pix   = got;
   end

   task automatic send(input int r, input int g, input int b, input int u,
                       input logic [EW-1:0] exp, input bit lat);
      bit done = 1'b0;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_r = CW'(r); in_g = CW'(g); in_b = CW'(b); in_user = USERW'(u);
         #1;
         if (in_ready) begin
            exp_q.push_back(exp);
            lat_q.push_back(lat ? cyc_cnt : -1);
            done = 1'b1;
         end
      end
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic drain();
      int t = 0;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   int px_r[30], px_g[30], px_b[30];

   initial begin
      int idx, base_out, n_in;
      logic v;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_h", int'(out_h), 0);
      chk("rst_out_s", int'(out_s), 0);
      chk("rst_out_v", int'(out_v), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", int'(in_ready), 1);

      // Directed vectors, back-to-back, with latency checks
      send(255,   0,   0, 0, pk(0,    255, 255, 0), 1'b1);
      send(  0, 255,   0, 1, pk(1920, 255, 255, 1), 1'b1);
      send(  0,   0, 255, 2, pk(3840, 255, 255, 2), 1'b1);
      send(200, 100,  50, 3, pk(320,  191, 200, 3), 1'b1);
      send(255, 128,   0, 0, pk(481,  255, 255, 0), 1'b1);
      send(255,   0, 255, 1, pk(4800, 255, 255, 1), 1'b1);
      send(128, 128, 128, 2, pk(0,      0, 128, 2), 1'b1);
      send(  0,   0,   0, 3, pk(0,      0,   0, 3), 1'b1);
      drain();

      // Backpressure: out_ready low for cycles 15..19 of a continuous stream
      for (int i = 0; i < 30; i++) begin
         px_r[i] = $urandom_range(0, 255);
         px_g[i] = $urandom_range(0, 255);
         px_b[i] = $urandom_range(0, 255);
      end
      idx = 0;
      base_out = n_out;
      for (int c = 0; c < 100 && idx < 30; c++) begin
         @(negedge clk);
         out_ready = !(c >= 15 && c <= 19);
         in_valid  = 1'b1;
         in_r = CW'(px_r[idx]); in_g = CW'(px_g[idx]); in_b = CW'(px_b[idx]);
         in_user = USERW'(idx);
         #1;
         chk("bp_in_ready", int'(in_ready), (c >= 15 && c <= 19) ? 0 : 1);
         if (in_ready) begin
            exp_q.push_back(model(px_r[idx], px_g[idx], px_b[idx], idx));
            lat_q.push_back(-1);
            idx++;
         end
      end
      drain();
      chk("bp_out_count", n_out - base_out, 30);

      // Gapped input
      n_in = 0;
      base_out = n_out;
      for (int c = 0; c < 40; c++) begin
         int r, g, b;
         @(negedge clk);
         v = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
         in_valid = v;
         in_r = CW'(r); in_g = CW'(g); in_b = CW'(b); in_user = USERW'(c);
         #1;
         if (v && in_ready) begin
            exp_q.push_back(model(r, g, b, c % 4));
            lat_q.push_back(-1);
            n_in++;
         end
      end
      drain();
      chk("gap_out_count", n_out - base_out, n_in);

      // Mid-stream reset with 8 pixels in flight
      for (int i = 0; i < 8; i++)
         send(10 * i + 20, 5 * i, 200 - 10 * i, i, model(10 * i + 20, 5 * i, 200 - 10 * i, i), 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      exp_q.delete();
      lat_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_out_valid", int'(out_valid), 0);
      chk("mrst_out_h", int'(out_h), 0);
      chk("mrst_out_s", int'(out_s), 0);
      chk("mrst_out_v", int'(out_v), 0);
      chk("mrst_out_user", int'(out_user), 0);
      chk("mrst_in_ready", int'(in_ready), 1);
      base_out = n_out;
      send( 30, 60, 90, 1, model(30, 60, 90, 1), 1'b1);
      send( 90, 60, 30, 2, model(90, 60, 30, 2), 1'b1);
      drain();
      repeat (LAT + 4) @(negedge clk);
      chk("mrst_out_count", n_out - base_out, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
